// File: rtl/adc_sched_pkg.sv
// ---------------------------------------------------------------------------
// adc_sched_pkg
// Shared types and default parameters for the ADC channel scheduler.
//   state_e          : scheduler FSM state encoding
//   DEF_NUM_CH       : default number of analog channels
//   DEF_DATA_W       : default ADC result width
//   DEF_SETTLE_CYC   : default mux settling delay in clk cycles
//   DEF_TIMEOUT_CYC  : default ADC valid timeout in clk cycles
// ---------------------------------------------------------------------------
package adc_sched_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SETTLE_CYC  = 64;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_DISCARD = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

endpackage : adc_sched_pkg

// File: rtl/adc_channel_scheduler_rr_next_channel.sv
// ---------------------------------------------------------------------------
// rr_next_channel
// Combinational round-robin search: finds the first set bit of mask strictly
// after position ptr, wrapping modulo NUM_CH. If ptr is the only set bit it
// is found again after a full wrap.
//   mask  in  NUM_CH  candidate channels
//   ptr   in  CH_W    last served channel
//   found out 1       at least one mask bit is set
//   idx   out CH_W    chosen channel (0 when found==0)
// ---------------------------------------------------------------------------
module rr_next_channel
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W:0] pos;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so the loop reads its own updates and no latch appears.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    // Walk from the farthest offset to the nearest so the nearest hit wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      pos = {1'b0, ptr} + (CH_W+1)'(k);
      if (pos >= (CH_W+1)'(NUM_CH)) begin
        pos = pos - (CH_W+1)'(NUM_CH);
      end
      if (mask[pos[CH_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[CH_W-1:0];
      end
    end
  end

endmodule : rr_next_channel

// File: rtl/adc_channel_scheduler.sv
// ---------------------------------------------------------------------------
// adc_channel_scheduler
// Time-shares one SAR conversion path among NUM_CH analog inputs. Each slot:
// select mux channel, wait SETTLE_CYC, enable the ADC, drop the first valid,
// capture the second, write the result bank and emit a tagged strobe.
// Pending one-shot requests take priority over the masked round-robin scan.
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   scan_en      in   enable continuous round-robin scan
//   ch_mask      in   channels included in the scan
//   single_req   in   one-shot request pulse for single_ch
//   single_ch    in   channel of the one-shot request
//   adc_valid    in   SAR conversion-complete strobe
//   adc_result   in   SAR result, qualified by adc_valid
//   mux_sel      out  analog mux select
//   adc_en       out  SAR controller enable
//   res_valid    out  one-cycle new-sample strobe
//   res_ch       out  channel tag of res_data
//   res_data     out  captured sample
//   rd_ch        in   result bank read index
//   rd_data      out  bank[rd_ch], combinational
//   busy         out  FSM not idle
//   timeout_err  out  sticky ADC timeout flag
// ---------------------------------------------------------------------------
module adc_channel_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              single_req,
  input  logic [CH_W-1:0]   single_ch,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_result,
  output logic [CH_W-1:0]   mux_sel,
  output logic              adc_en,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     mux_sel_q, mux_sel_d;
  logic                adc_en_q, adc_en_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                pend_q, pend_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;

  logic [DATA_W-1:0]   bank_q [NUM_CH];
  logic                bank_we;

  logic                rr_found;
  logic [CH_W-1:0]     rr_idx;
  logic                single_ch_ok;
  logic                tmo_last;
  logic                slot_go;
  logic [CH_W-1:0]     slot_ch;

  rr_next_channel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .mask  (ch_mask),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Requests naming a channel that does not exist are dropped.
  assign single_ch_ok = (32'(single_ch) < NUM_CH);
  // Last cycle of the shared DISCARD+CAPTURE window.
  assign tmo_last     = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d       = state_q;
    mux_sel_d     = mux_sel_q;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q;
    settle_cnt_d  = settle_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    pend_d        = pend_q;
    pend_ch_d     = pend_ch_q;
    bank_we       = 1'b0;
    slot_go       = 1'b0;
    slot_ch       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          slot_go = 1'b1;
          slot_ch = pend_ch_q;
          pend_d  = 1'b0;
        end else if (scan_en && rr_found) begin
          slot_go  = 1'b1;
          slot_ch  = rr_idx;
          rr_ptr_d = rr_idx;
        end
        if (slot_go) begin
          mux_sel_d    = slot_ch;
          settle_cnt_d = SET_W'(SETTLE_CYC);
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SET_W'(1)) begin
          tmo_cnt_d = '0;
          state_d   = ST_DISCARD;
        end else begin
          settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
      end

      // The first valid may belong to a conversion started before the mux
      // settled, so it only advances the state.
      ST_DISCARD: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (tmo_last) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (adc_valid) begin
          state_d = ST_CAPTURE;
        end
      end

      // A capturing valid on the final timeout cycle still counts.
      ST_CAPTURE: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (adc_valid) begin
          res_data_d = adc_result;
          res_ch_d   = mux_sel_q;
          bank_we    = 1'b1;
          state_d    = ST_EMIT;
        end else if (tmo_last) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_EMIT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request arriving in the same cycle the old one is consumed survives.
    if (single_req && single_ch_ok) begin
      pend_d    = 1'b1;
      pend_ch_d = single_ch;
    end

    // Outputs are decoded from the next state so they are registered.
    adc_en_d    = (state_d == ST_DISCARD) || (state_d == ST_CAPTURE);
    res_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mux_sel_q     <= '0;
      adc_en_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      settle_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      rr_ptr_q      <= CH_W'(NUM_CH - 1);
      pend_q        <= 1'b0;
      pend_ch_q     <= '0;
    end else begin
      state_q       <= state_d;
      mux_sel_q     <= mux_sel_d;
      adc_en_q      <= adc_en_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      settle_cnt_q  <= settle_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      pend_q        <= pend_d;
      pend_ch_q     <= pend_ch_d;
    end
  end

  // NOTE: the result bank is a small flop array that must read as zero after
  // reset, so it is cleared explicitly; this also keeps it out of RAM macros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bank_we) begin
      bank_q[mux_sel_q] <= adc_result;
    end
  end

  // Reads see the pre-write contents during the capture cycle.
  assign rd_data     = bank_q[rd_ch];

  assign mux_sel     = mux_sel_q;
  assign adc_en      = adc_en_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule : adc_channel_scheduler

// File: tb/tb_adc_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_channel_scheduler
// Randomized scoreboard bench: a slot-level reference model predicts each
// sample (channel, data); a monitor pops predictions on every res_valid.
// A SAR model answers adc_en with a junk first valid then the channel value.
// ---------------------------------------------------------------------------
module tb_adc_channel_scheduler;

  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int DATA_W      = 8;
  localparam int SETTLE_CYC  = 64;
  localparam int TIMEOUT_CYC = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic              scan_en;
  logic [NUM_CH-1:0] ch_mask;
  logic              single_req;
  logic [CH_W-1:0]   single_ch;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_result = '0;
  logic [CH_W-1:0]   mux_sel;
  logic              adc_en;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              timeout_err;

  adc_channel_scheduler #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .DATA_W      (DATA_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .ch_mask     (ch_mask),
    .single_req  (single_req),
    .single_ch   (single_ch),
    .adc_valid   (adc_valid),
    .adc_result  (adc_result),
    .mux_sel     (mux_sel),
    .adc_en      (adc_en),
    .res_valid   (res_valid),
    .res_ch      (res_ch),
    .res_data    (res_data),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  typedef struct {
    int          ch;
    logic [7:0]  data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       cur;
  int         m_ptr;
  bit         m_pend;
  int         m_pend_ch;
  logic [7:0] m_bank [NUM_CH];
  logic [7:0] data_tab [NUM_CH];

  function automatic void m_reset();
    m_ptr  = NUM_CH - 1;
    m_pend = 1'b0;
    for (int k = 0; k < NUM_CH; k++) m_bank[k] = 8'h00;
  endfunction

  // Priority request first, else next masked channel after the pointer.
  function automatic int m_decide();
    if (m_pend) begin
      m_pend = 1'b0;
      return m_pend_ch;
    end
    if (scan_en && ch_mask != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (m_ptr + k) % NUM_CH;
        if (ch_mask[c]) begin
          m_ptr = c;
          return c;
        end
      end
    end
    return -1;
  endfunction

  // ---------------- SAR model ----------------
  bit sar_mute  = 1'b0;
  int sar_fixed = 20;
  int sar_cnt   = 0;
  int sar_nv    = 0;
  int sar_d     = 20;

  always @(negedge clk) begin
    adc_valid = 1'b0;
    if (adc_en) begin
      sar_cnt++;
      if (!sar_mute && sar_cnt >= sar_d) begin
        adc_valid  = 1'b1;
        adc_result = (sar_nv == 0) ? 8'h11 : data_tab[mux_sel];
        sar_nv++;
        sar_cnt = 0;
      end
    end else begin
      sar_cnt = 0;
      sar_nv  = 0;
      sar_d   = (sar_fixed > 0) ? sar_fixed : int'($urandom_range(2, 30));
      // Stray strobes while disabled must be ignored.
      if ($urandom_range(0, 7) == 0) begin
        adc_valid  = 1'b1;
        adc_result = 8'hEE;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && res_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("res_ch", 32'(res_ch), e.ch);
        check("res_data", 32'(res_data), 32'(e.data));
      end
    end
  end

  // ---------------- timing checker ----------------
  bit              prev_busy, prev_en, prev_terr, in_settle;
  logic [CH_W-1:0] prev_mux, start_mux;
  int              settle_n, en_n;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_busy = 0; prev_en = 0; prev_terr = 0; in_settle = 0;
      prev_mux = '0; start_mux = '0; settle_n = 0; en_n = 0;
    end else begin
      if (busy && !prev_busy) begin
        start_mux = mux_sel;
        in_settle = 1;
        settle_n  = 0;
      end else if (mux_sel !== prev_mux) begin
        check("mux_hold", 32'(mux_sel), 32'(prev_mux));
      end
      if (in_settle && !adc_en) settle_n++;
      if (adc_en && !prev_en) begin
        check("settle_len", settle_n, SETTLE_CYC);
        in_settle = 0;
        en_n      = 0;
      end
      if (adc_en) en_n++;
      if (timeout_err && !prev_terr) begin
        check("timeout_en_falls", {prev_en, adc_en}, 2'b10);
        check("timeout_en_cycles", en_n, TIMEOUT_CYC);
        check("timeout_idle", 32'(busy), 32'd0);
      end
      if (res_valid) check("mux_through_emit", 32'(mux_sel), 32'(start_mux));
      prev_busy = busy; prev_en = adc_en; prev_terr = timeout_err; prev_mux = mux_sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_req(input int c);
    single_req = 1'b1;
    single_ch  = CH_W'(c);
    m_pend     = 1'b1;
    m_pend_ch  = c;
    @(negedge clk);
    single_req = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (res_valid !== 1'b1 && n < 400);
    if (res_valid !== 1'b1) check("res_valid_wait", 32'd0, 32'd1);
  endtask

  // One slot: predict, optionally disturb inputs mid-slot, await the result.
  task automatic run_slot(input bit rnd, input bit req, input int rch, input bit drop_scan);
    int ch;
    if (rnd) begin
      for (int k = 0; k < NUM_CH; k++) begin
        data_tab[k] = 8'($urandom_range(0, 255));
        if (data_tab[k] == 8'h11) data_tab[k] = 8'h12;
      end
    end
    ch = m_decide();
    if (ch < 0) return;
    cur.ch   = ch;
    cur.data = data_tab[ch];
    sb_q.push_back(cur);
    if (rnd || req || drop_scan) begin
      repeat ($urandom_range(5, 40)) @(negedge clk);
      if (drop_scan) scan_en = 1'b0;
      if (req) pulse_req(rch);
      if (rnd) begin
        if ($urandom_range(0, 1) == 1) ch_mask = NUM_CH'($urandom_range(1, 15));
        if ($urandom_range(0, 2) == 0) pulse_req(int'($urandom_range(0, NUM_CH-1)));
        if ($urandom_range(0, 4) == 0) pulse_req(int'($urandom_range(0, NUM_CH-1)));
      end
    end
    wait_res();
    m_bank[cur.ch] = cur.data;
    rd_ch = CH_W'($urandom_range(0, NUM_CH-1));
    #1;
    check("rd_data", 32'(rd_data), 32'(m_bank[rd_ch]));
  endtask

  task automatic drain();
    while (m_pend) run_slot(0, 0, 0, 0);
  endtask

  task automatic idle_check(input string name);
    bit any = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any = any | busy | res_valid;
    end
    check(name, 32'(any), 32'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    scan_en    = 1'b0;
    ch_mask    = '0;
    single_req = 1'b1;
    single_ch  = 2'd2;
    rd_ch      = '0;
    for (int k = 0; k < NUM_CH; k++) data_tab[k] = 8'hA0 + 8'(k);
    m_reset();

    // Reset hold with a request asserted throughout.
    repeat (3) @(negedge clk);
    check("rst_outputs", {mux_sel, adc_en, res_valid, res_ch, res_data, busy, timeout_err}, 32'd0);
    check("rst_bank", 32'(rd_data), 32'd0);
    reset      = 1'b1;
    single_req = 1'b0;
    idle_check("no_pending_after_reset");

    // Directed scan order 0,1,3,0,1,3.
    ch_mask = 4'b1011;
    scan_en = 1'b1;
    repeat (6) run_slot(0, 0, 0, 0);

    // Priority request mid-slot on ch0: ch0, ch2, then ch1.
    ch_mask = 4'b0011;
    run_slot(0, 1, 2, 0);
    run_slot(0, 0, 0, 0);
    run_slot(0, 0, 0, 0);
    rd_ch = 2'd2;
    #1;
    check("rd_prio_ch2", 32'(rd_data), 32'hA2);

    // Randomized scanning with mask changes and requests.
    sar_fixed = 0;
    repeat (24) run_slot(1, 0, 0, 0);

    // scan_en dropped mid-slot: slot completes, then idle.
    run_slot(0, 0, 0, 1);
    drain();
    idle_check("idle_after_scan_off");

    // Timeout: SAR never answers.
    sar_mute = 1'b1;
    ch_mask  = 4'b0100;
    scan_en  = 1'b1;
    void'(m_decide());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timeout_err !== 1'b1 && n < SETTLE_CYC + TIMEOUT_CYC + 50);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    sar_mute = 1'b0;
    run_slot(0, 0, 0, 1);
    drain();
    idle_check("idle_after_timeout_slot");
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during CAPTURE aborts the slot.
    sar_fixed = 20;
    ch_mask   = 4'b0010;
    scan_en   = 1'b1;
    cur.ch    = m_decide();
    cur.data  = data_tab[1];
    sb_q.push_back(cur);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(adc_en === 1'b1 && sar_nv == 1) && n < 400);
    check("reached_capture", 32'(adc_en), 32'd1);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_mid_adc_en", 32'(adc_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_res_valid", 32'(res_valid), 32'd0);
    check("rst_mid_timeout_err", 32'(timeout_err), 32'd0);
    for (int k = 0; k < NUM_CH; k++) begin
      rd_ch = CH_W'(k);
      #1;
      check("rst_mid_bank", 32'(rd_data), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    ch_mask = 4'b1111;
    run_slot(0, 0, 0, 1);
    drain();
    idle_check("idle_at_end");
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_adc_channel_scheduler

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
- Time-shares one SAR ADC conversion path (SAR controller + capture register) among NUM_CH analog inputs through an external analog mux.
- Sequences the mux select, settling delay, ADC enable and result capture.
- Services a continuous masked round-robin scan plus one-shot priority requests.
- Results go to a per-channel result bank and are also emitted as a tagged one-cycle stream toward the averaging/scaling datapath.

Parameters:
- NUM_CH, 4: number of analog channels (2..8).
- CH_W, $clog2(NUM_CH): channel index width.
- DATA_W, 8: ADC result width.
- SETTLE_CYC, 64: clk cycles between a mux change and ADC enable (>=1).
- TIMEOUT_CYC, 4096: max cycles to wait for an ADC valid (>=16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- scan_en  in  1  level; enables continuous round-robin scanning.
- ch_mask  in  NUM_CH  channels included in the scan; sampled at each slot decision.
- single_req  in  1  one-shot request pulse for channel single_ch.
- single_ch  in  CH_W  channel for single_req; captured with the request.
- adc_valid  in  1  one-cycle strobe from the SAR controller, conversion complete.
- adc_result  in  DATA_W  SAR result, qualified by adc_valid.
- mux_sel  out  CH_W  analog mux select.
- adc_en  out  1  SAR controller enable.
- res_valid  out  1  one-cycle strobe, new sample.
- res_ch  out  CH_W  channel tag of res_data.
- res_data  out  DATA_W  captured sample.
- rd_ch  in  CH_W  bank read index.
- rd_data  out  DATA_W  bank[rd_ch]; combinational read.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky; set on ADC timeout, cleared only by reset.

Behaviour:
Reset (reset==0 at a clock edge):
- State IDLE; mux_sel=0, adc_en=0, res_valid=0, res_ch=0, res_data=0, busy=0, timeout_err=0.
- All bank entries 0; pending single request cleared; round-robin pointer = NUM_CH-1, so channel 0 is first.
- Reset mid-conversion aborts immediately; no res_valid is issued.

Single-request latch:
- single_req sets a pending flag and captures single_ch.
- A single_req arriving while one is pending overwrites the channel (last wins).
- single_ch >= NUM_CH is ignored.

FSM states: IDLE, SETTLE, DISCARD, CAPTURE, EMIT.
- IDLE: slot decision each cycle.
  - Pending single request wins: its channel is chosen and the flag is cleared.
  - Otherwise, if scan_en and ch_mask!=0: the next set mask bit strictly after the RR pointer, wrapping modulo NUM_CH, is chosen and the pointer is updated.
  - Otherwise stay in IDLE.
  - On a choice: mux_sel<=channel, settle counter loaded, go to SETTLE.
- SETTLE: adc_en=0; count SETTLE_CYC cycles, then go to DISCARD.
- DISCARD: adc_en=1.
  - The first adc_valid is discarded, because its conversion may have started before settling. Go to CAPTURE.
- CAPTURE: adc_en=1.
  - The next adc_valid latches adc_result into res_data and bank[mux_sel]; go to EMIT.
- EMIT: adc_en=0; res_valid=1 for exactly this cycle with res_ch=mux_sel; go to IDLE.
- Timeout: one timer covers DISCARD and CAPTURE together.
  - If TIMEOUT_CYC cycles elapse without the required valids: set timeout_err, adc_en=0, return to IDLE.
  - No res_valid and no bank write on timeout.

Timing and boundaries:
- Latency from slot decision to res_valid = 1 + SETTLE_CYC + ADC time to two valids + 1 cycles.
- adc_valid outside DISCARD/CAPTURE is ignored.
- mux_sel changes only on the IDLE->SETTLE transition; it holds through EMIT and holds in IDLE.
- ch_mask changes take effect at the next slot decision only. The in-flight conversion completes.
- scan_en deasserted mid-slot: the current slot completes, then the FSM idles.
- Single mask bit: the same channel is rescanned every slot.
- Back-to-back slots: the IDLE decision happens in the cycle after EMIT, so there is at least one idle cycle between slots.
- Bank write and rd_ch of the same entry in the same cycle: rd_data shows the old value that cycle.

Decomposition:
- Shared package adc_sched_pkg holds:
  - the state enum type;
  - localparam defaults for NUM_CH, SETTLE_CYC, TIMEOUT_CYC.
- One natural sub-module: rr_next_channel.
  - Combinational next-set-bit-after-pointer search with wrap.
  - Inputs mask and ptr; outputs found and idx.
  - Reused by the top FSM.

Test Plan:
1. Reset hold: reset=0 for 3 cycles while single_req=1 -> all outputs 0, busy=0, and no request pending after release.
2. Scan order: ch_mask=4'b1011, scan_en=1; SAR model gives valid 20 cycles after adc_en and result=8'hA0+ch -> res_ch sequence 0,1,3,0,1,3; res_data A0,A1,A3; mux_sel stable from SETTLE through EMIT; 64 cycles adc_en=0 after each mux change.
3. Priority: scanning mask 4'b0011; single_req with single_ch=2 pulsed mid-slot on ch0 -> ch0 completes, next res_ch=2, then scan resumes at ch1; rd_ch=2 returns 8'hA2.
4. Discard rule: model returns 8'h11 on first valid then 8'h55 -> res_data=8'h55, never 8'h11; exactly one res_valid per slot.
5. Timeout: SAR model never asserts valid -> timeout_err=1 after exactly TIMEOUT_CYC cycles of adc_en=1, no res_valid, FSM back to IDLE, next slot proceeds.
6. Mid-conversion reset: assert reset during CAPTURE -> next cycle adc_en=0, busy=0, bank all zero; after release the first slot is ch0.
